// File: rtl/mem_port_arbiter.sv
// Arbitrates one fixed-latency single-ported memory between instruction fetch and load/store.
// Optional MEMARB_IBUF_EN adds a one-entry fetch buffer that serves repeated fetches without a memory access.
module mem_port_arbiter #(
   parameter int MEM_LATENCY = 2,
   parameter int ADDR_W      = 32,
   parameter int DATA_W      = 32
) (
   input  logic              clock_i,
   input  logic              reset_ni,
   input  logic              enable_i,
   input  logic              imem_req_i,
   input  logic [ADDR_W-1:0] imem_addr_i,
   output logic [DATA_W-1:0] imem_rdata_o,
   output logic              imem_wait_o,
   input  logic              dmem_read_i,
   input  logic              dmem_write_i,
   input  logic [ADDR_W-1:0] dmem_addr_i,
   input  logic [DATA_W-1:0] dmem_wdata_i,
   output logic [DATA_W-1:0] dmem_rdata_o,
   output logic              dmem_wait_o,
   output logic              mem_en_o,
   output logic              mem_we_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [DATA_W-1:0] mem_wdata_o,
   input  logic [DATA_W-1:0] mem_rdata_i
);

   // state  | meaning
   // S_IDLE | no access in flight, arbitrate when enabled
   // S_DACC | load/store access counting down
   // S_IACC | fetch access counting down
   typedef enum logic [1:0] {S_IDLE, S_DACC, S_IACC} state_t;

   localparam int              CNT_W    = $clog2(MEM_LATENCY) + 1;
   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MEM_LATENCY - 1);

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                last_d_q, last_d_d;
   logic                mem_en_q, mem_en_d;
   logic                mem_we_q, mem_we_d;
   logic                we_lat_q, we_lat_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic [DATA_W-1:0]   irdata_q, irdata_d;
   logic [DATA_W-1:0]   drdata_q, drdata_d;

   logic                i_done, d_done, d_pend, i_pend, ibuf_hit;
   logic [DATA_W-1:0]   ibuf_rdata;

   assign i_done = (state_q == S_IACC) && (cnt_q == '0);
   assign d_done = (state_q == S_DACC) && (cnt_q == '0);
   assign d_pend = dmem_read_i | dmem_write_i;
   assign i_pend = imem_req_i & ~ibuf_hit;

`ifdef MEMARB_IBUF_EN
   logic                ibuf_valid_q, ibuf_valid_d;
   logic [ADDR_W-1:0]   ibuf_addr_q, ibuf_addr_d;
   logic [DATA_W-1:0]   ibuf_data_q, ibuf_data_d;

   assign ibuf_hit   = (state_q == S_IDLE) && enable_i && imem_req_i && ibuf_valid_q
                       && (imem_addr_i == ibuf_addr_q);
   assign ibuf_rdata = ibuf_data_q;

   // The latched store address is the one actually written, even if the request dropped.
   always_comb begin
      ibuf_valid_d = ibuf_valid_q;
      ibuf_addr_d  = ibuf_addr_q;
      ibuf_data_d  = ibuf_data_q;
      if (i_done) begin
         ibuf_valid_d = 1'b1;
         ibuf_addr_d  = addr_q;
         ibuf_data_d  = mem_rdata_i;
      end else if (d_done && we_lat_q && (addr_q == ibuf_addr_q)) begin
         ibuf_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clock_i or negedge reset_ni) begin
      if (!reset_ni) begin
         ibuf_valid_q <= 1'b0;
         ibuf_addr_q  <= '0;
         ibuf_data_q  <= '0;
      end else begin
         ibuf_valid_q <= ibuf_valid_d;
         ibuf_addr_q  <= ibuf_addr_d;
         ibuf_data_q  <= ibuf_data_d;
      end
   end
`else
   assign ibuf_hit   = 1'b0;
   assign ibuf_rdata = '0;
`endif

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      last_d_d = last_d_q;
      mem_en_d = mem_en_q;
      mem_we_d = 1'b0;
      we_lat_d = we_lat_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      irdata_d = irdata_q;
      drdata_d = drdata_q;
      case (state_q)
         S_IDLE: begin
            if (ibuf_hit) irdata_d = ibuf_rdata;
            if (enable_i) begin
               if (d_pend && (!i_pend || !last_d_q)) begin
                  state_d  = S_DACC;
                  cnt_d    = CNT_INIT;
                  last_d_d = 1'b1;
                  mem_en_d = 1'b1;
                  we_lat_d = dmem_write_i;
                  mem_we_d = dmem_write_i && (MEM_LATENCY == 1);
                  addr_d   = dmem_addr_i;
                  wdata_d  = dmem_wdata_i;
               end else if (i_pend) begin
                  state_d  = S_IACC;
                  cnt_d    = CNT_INIT;
                  last_d_d = 1'b0;
                  mem_en_d = 1'b1;
                  we_lat_d = 1'b0;
                  addr_d   = imem_addr_i;
               end
            end
         end
         S_DACC, S_IACC: begin
            if (cnt_q == '0) begin
               state_d  = S_IDLE;
               mem_en_d = 1'b0;
               we_lat_d = 1'b0;
               if (state_q == S_DACC) drdata_d = mem_rdata_i;
               else                   irdata_d = mem_rdata_i;
            end else begin
               cnt_d    = cnt_q - CNT_W'(1);
               // Strobe lands on the final cycle only, so a store writes exactly once.
               mem_we_d = we_lat_q && (state_q == S_DACC) && (cnt_q == CNT_W'(1));
            end
         end
         default: begin
            state_d  = S_IDLE;
            mem_en_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clock_i or negedge reset_ni) begin
      if (!reset_ni) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         last_d_q <= 1'b0;
         mem_en_q <= 1'b0;
         mem_we_q <= 1'b0;
         we_lat_q <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
         irdata_q <= '0;
         drdata_q <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         last_d_q <= last_d_d;
         mem_en_q <= mem_en_d;
         mem_we_q <= mem_we_d;
         we_lat_q <= we_lat_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         irdata_q <= irdata_d;
         drdata_q <= drdata_d;
      end
   end

   assign mem_en_o     = mem_en_q;
   assign mem_we_o     = mem_we_q;
   assign mem_addr_o   = addr_q;
   assign mem_wdata_o  = wdata_q;
   assign imem_wait_o  = imem_req_i & ~(i_done | ibuf_hit);
   assign dmem_wait_o  = d_pend & ~d_done;
   assign imem_rdata_o = i_done ? mem_rdata_i : (ibuf_hit ? ibuf_rdata : irdata_q);
   assign dmem_rdata_o = d_done ? mem_rdata_i : drdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter (MEM_LATENCY=2) with a small backing memory and a grant-order scoreboard.
// Checks the MEMARB_IBUF_EN fetch buffer when that macro is defined.
module tb_mem_port_arbiter;

   logic        clk = 1'b0;
   logic        reset_n, enable;
   logic        imem_req, dmem_read, dmem_write;
   logic [31:0] imem_addr, dmem_addr, dmem_wdata;
   logic [31:0] imem_rdata, dmem_rdata, mem_addr, mem_wdata, mem_rdata;
   logic        imem_wait, dmem_wait, mem_en, mem_we;

   int n_pass = 0;
   int n_total = 0;
   int we_count = 0;

   typedef struct {logic is_d; logic [31:0] data;} exp_t;
   exp_t        sb[$];
   logic [31:0] iq[$];
   logic [31:0] dq[$];

   bit   [255:0] wr_valid;
   logic [31:0]  wr_data [256];

   always #5 clk = ~clk;

   mem_port_arbiter #(.MEM_LATENCY(2), .ADDR_W(32), .DATA_W(32)) dut (
      .clock_i(clk), .reset_ni(reset_n), .enable_i(enable),
      .imem_req_i(imem_req), .imem_addr_i(imem_addr), .imem_rdata_o(imem_rdata), .imem_wait_o(imem_wait),
      .dmem_read_i(dmem_read), .dmem_write_i(dmem_write), .dmem_addr_i(dmem_addr),
      .dmem_wdata_i(dmem_wdata), .dmem_rdata_o(dmem_rdata), .dmem_wait_o(dmem_wait),
      .mem_en_o(mem_en), .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
      .mem_rdata_i(mem_rdata)
   );

   function automatic logic [31:0] init_word(input logic [31:0] a);
      if (a == 32'h40) return 32'h8C01_0004;
      return {a[15:0] ^ 16'h5A5A, ~a[15:0]};
   endfunction

   assign mem_rdata = !mem_en ? 32'hBAD0_BAD0 :
                      (wr_valid[mem_addr[9:2]] ? wr_data[mem_addr[9:2]] : init_word(mem_addr));

   always @(posedge clk) begin
      if (mem_we) begin
         wr_valid[mem_addr[9:2]] <= 1'b1;
         wr_data[mem_addr[9:2]]  <= mem_wdata;
         we_count <= we_count + 1;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   task automatic idle_inputs();
      imem_req = 1'b0; imem_addr = '0;
      dmem_read = 1'b0; dmem_write = 1'b0; dmem_addr = '0; dmem_wdata = '0;
   endtask

   // Called at a negedge; that cycle is cycle 0. Ports request from iq/dq, completions pop sb in order.
   task automatic service(input int budget, output int i_cyc, output int d_cyc,
                          output logic [15:0] en_trace);
      int   c = 0;
      exp_t e;
      i_cyc = -1; d_cyc = -1; en_trace = '0;
      imem_req  = (iq.size() > 0); imem_addr = (iq.size() > 0) ? iq[0] : 32'h0;
      dmem_read = (dq.size() > 0); dmem_addr = (dq.size() > 0) ? dq[0] : 32'h0;
      forever begin
         #1;
         if (c < 16) en_trace[c] = mem_en;
         if (imem_req && !imem_wait) begin
            chk("sb_nonempty_i", 32'(sb.size() > 0), 32'd1);
            if (sb.size() > 0) begin
               e = sb.pop_front();
               chk("grant_order_i", 32'(e.is_d), 32'd0);
               chk("imem_rdata", imem_rdata, e.data);
            end
            i_cyc = c;
            if (iq.size() > 0) void'(iq.pop_front());
         end
         if ((dmem_read || dmem_write) && !dmem_wait) begin
            chk("sb_nonempty_d", 32'(sb.size() > 0), 32'd1);
            if (sb.size() > 0) begin
               e = sb.pop_front();
               chk("grant_order_d", 32'(e.is_d), 32'd1);
               chk("dmem_rdata", dmem_rdata, e.data);
            end
            d_cyc = c;
            if (dq.size() > 0) void'(dq.pop_front());
         end
         if (sb.size() == 0) break;
         if (c >= budget) begin
            chk("svc_timeout", 32'(sb.size()), 32'd0);
            sb.delete(); iq.delete(); dq.delete();
            break;
         end
         @(negedge clk); c++;
         imem_req  = (iq.size() > 0); imem_addr = (iq.size() > 0) ? iq[0] : 32'h0;
         dmem_read = (dq.size() > 0); dmem_addr = (dq.size() > 0) ? dq[0] : 32'h0;
      end
      @(negedge clk);
      idle_inputs();
   endtask

   initial begin
      int          ic, dc, we0;
      logic [15:0] tr;
      reset_n = 1'b0; enable = 1'b1;
      idle_inputs();

      // reset state
      @(negedge clk); #1;
      chk("rst_mem_en", 32'(mem_en), 32'd0);
      chk("rst_mem_we", 32'(mem_we), 32'd0);
      chk("rst_mem_addr", mem_addr, 32'h0);
      chk("rst_mem_wdata", mem_wdata, 32'h0);
      chk("rst_imem_rdata", imem_rdata, 32'h0);
      chk("rst_dmem_rdata", dmem_rdata, 32'h0);
      @(negedge clk); reset_n = 1'b1;
      @(negedge clk);

      // single fetch latency
      imem_req = 1'b1; imem_addr = 32'h40; #1;
      chk("t1_wait_c0", 32'(imem_wait), 32'd1);
      chk("t1_en_c0", 32'(mem_en), 32'd0);
      @(negedge clk); #1;
      chk("t1_wait_c1", 32'(imem_wait), 32'd1);
      chk("t1_en_c1", 32'(mem_en), 32'd1);
      chk("t1_addr_c1", mem_addr, 32'h40);
      @(negedge clk); #1;
      chk("t1_wait_c2", 32'(imem_wait), 32'd0);
      chk("t1_rdata_c2", imem_rdata, 32'h8C01_0004);
      @(negedge clk); idle_inputs(); #1;
      chk("t1_en_c3", 32'(mem_en), 32'd0);
      chk("t1_rdata_held", imem_rdata, 32'h8C01_0004);
      @(negedge clk);

      // simultaneous requests with last grant I: data first
      iq = '{32'h44}; dq = '{32'h80};
      sb.push_back('{1'b1, init_word(32'h80)});
      sb.push_back('{1'b0, init_word(32'h44)});
      service(20, ic, dc, tr);
      chk("t2_d_cycle", 32'(dc), 32'd2);
      chk("t2_i_cycle", 32'(ic), 32'd5);
      @(negedge clk);

      // continuous requests alternate with a one-cycle gap
      iq = '{32'h48, 32'h4C}; dq = '{32'h80, 32'h84};
      sb.push_back('{1'b1, init_word(32'h80)});
      sb.push_back('{1'b0, init_word(32'h48)});
      sb.push_back('{1'b1, init_word(32'h84)});
      sb.push_back('{1'b0, init_word(32'h4C)});
      service(30, ic, dc, tr);
      chk("t3_en_trace", 32'(tr[11:0]), 32'h0DB6);
      chk("t3_last_i", 32'(ic), 32'd11);
      @(negedge clk);

      // store: one write strobe on the final cycle
      we0 = we_count;
      dmem_write = 1'b1; dmem_addr = 32'h100; dmem_wdata = 32'hDEAD_BEEF; #1;
      chk("t4_we_c0", 32'(mem_we), 32'd0);
      @(negedge clk); #1;
      chk("t4_we_c1", 32'(mem_we), 32'd0);
      chk("t4_wdata_c1", mem_wdata, 32'hDEAD_BEEF);
      @(negedge clk); #1;
      chk("t4_we_c2", 32'(mem_we), 32'd1);
      chk("t4_addr_c2", mem_addr, 32'h100);
      chk("t4_wdata_c2", mem_wdata, 32'hDEAD_BEEF);
      chk("t4_dwait_c2", 32'(dmem_wait), 32'd0);
      @(negedge clk); idle_inputs(); #1;
      chk("t4_we_c3", 32'(mem_we), 32'd0);
      chk("t4_we_count", 32'(we_count - we0), 32'd1);
      @(negedge clk);
      dq = '{32'h100};
      sb.push_back('{1'b1, 32'hDEAD_BEEF});
      service(10, ic, dc, tr);
      chk("t4_load_cycle", 32'(dc), 32'd2);

      // requests dropped mid-access still complete
      @(negedge clk);
      imem_req = 1'b1; imem_addr = 32'h50;
      @(negedge clk); imem_req = 1'b0; #1;
      chk("drop_en_c1", 32'(mem_en), 32'd1);
      @(negedge clk); #1;
      chk("drop_en_c2", 32'(mem_en), 32'd1);
      @(negedge clk); #1;
      chk("drop_irdata", imem_rdata, init_word(32'h50));
      we0 = we_count;
      @(negedge clk);
      dmem_write = 1'b1; dmem_addr = 32'h104; dmem_wdata = 32'hCAFE_F00D;
      @(negedge clk); idle_inputs();
      repeat (3) @(negedge clk);
      chk("drop_store_we", 32'(we_count - we0), 32'd1);
      dq = '{32'h104};
      sb.push_back('{1'b1, 32'hCAFE_F00D});
      service(10, ic, dc, tr);

      // enable low holds IDLE; in-flight access completes regardless
      @(negedge clk);
      enable = 1'b0; imem_req = 1'b1; imem_addr = 32'h60;
      for (int k = 0; k < 3; k++) begin
         #1;
         chk("en0_iwait", 32'(imem_wait), 32'd1);
         chk("en0_mem_en", 32'(mem_en), 32'd0);
         @(negedge clk);
      end
      enable = 1'b1;
      iq = '{32'h60};
      sb.push_back('{1'b0, init_word(32'h60)});
      service(10, ic, dc, tr);
      chk("en1_i_cycle", 32'(ic), 32'd2);
      @(negedge clk);
      dmem_read = 1'b1; dmem_addr = 32'h88;
      @(negedge clk); enable = 1'b0;
      @(negedge clk); #1;
      chk("en0_inflight_dwait", 32'(dmem_wait), 32'd0);
      chk("en0_inflight_rdata", dmem_rdata, init_word(32'h88));
      @(negedge clk); idle_inputs(); enable = 1'b1;
      @(negedge clk);

      // async reset during a data access
      dmem_read = 1'b1; dmem_addr = 32'h8C;
      @(negedge clk); #1;
      chk("t5_en_before", 32'(mem_en), 32'd1);
      #2 reset_n = 1'b0; #1;
      chk("t5_en_rst", 32'(mem_en), 32'd0);
      chk("t5_we_rst", 32'(mem_we), 32'd0);
      chk("t5_addr_rst", mem_addr, 32'h0);
      chk("t5_drdata_rst", dmem_rdata, 32'h0);
      chk("t5_dwait_rst", 32'(dmem_wait), 32'd1);
      @(negedge clk); reset_n = 1'b1;
      iq = '{32'h90}; dq = '{32'h8C};
      sb.push_back('{1'b1, init_word(32'h8C)});
      sb.push_back('{1'b0, init_word(32'h90)});
      service(20, ic, dc, tr);
      chk("t5_d_cycle", 32'(dc), 32'd2);
      chk("t5_i_cycle", 32'(ic), 32'd5);
      @(negedge clk);

      // repeated fetch of 0x40, then store to it, then fetch again
      iq = '{32'h40};
      sb.push_back('{1'b0, 32'h8C01_0004});
      service(10, ic, dc, tr);
      chk("t6_first_fetch", 32'(ic), 32'd2);
      @(negedge clk);
`ifdef MEMARB_IBUF_EN
      imem_req = 1'b1; imem_addr = 32'h40; #1;
      chk("t6_hit_wait", 32'(imem_wait), 32'd0);
      chk("t6_hit_rdata", imem_rdata, 32'h8C01_0004);
      chk("t6_hit_en_c0", 32'(mem_en), 32'd0);
      @(negedge clk); idle_inputs(); #1;
      chk("t6_hit_en_c1", 32'(mem_en), 32'd0);
`else
      iq = '{32'h40};
      sb.push_back('{1'b0, 32'h8C01_0004});
      service(10, ic, dc, tr);
      chk("t6_second_fetch", 32'(ic), 32'd2);
`endif
      @(negedge clk);
      dmem_write = 1'b1; dmem_addr = 32'h40; dmem_wdata = 32'h1122_3344;
      repeat (3) @(negedge clk);
      idle_inputs();
      @(negedge clk);
      iq = '{32'h40};
      sb.push_back('{1'b0, 32'h1122_3344});
      service(10, ic, dc, tr);
      chk("t6_third_fetch", 32'(ic), 32'd2);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
